// File: rtl/cache_pkg.sv
// Shared types and address helpers for the cache data array and its banks.
package cache_pkg;

  localparam int unsigned BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_FILL = 2'd1,
    RF_DONE = 2'd2
  } refill_state_t;

  // Byte offset within a line; the caller narrows the result to OFF_W bits.
  function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int unsigned off_w);
    return addr & ((64'd1 << off_w) - 64'd1);
  endfunction

  // Set index; the caller narrows the result to IDX_W bits.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w);
    return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_data_bank.sv
// One way of the data array: registered read port and a byte-masked 8-byte write port,
// both wrapping inside the addressed line.
module cache_data_bank
  import cache_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned SETS       = 64,
  parameter int unsigned RD_BYTES   = 8,
  localparam int unsigned OFF_W     = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W     = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [OFF_W-1:0]      rd_off,
  output logic [8*RD_BYTES-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [OFF_W-1:0]      wr_off,
  input  logic [BEAT_BYTES-1:0] wr_strb,
  input  logic [63:0]           wr_data
);

  logic [7:0] mem [SETS][LINE_BYTES];

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        if (wr_strb[i]) mem[wr_idx][OFF_W'(rd_wrap(wr_off, i))] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read register samples pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int i = 0; i < RD_BYTES; i++) begin
        rd_data[8*i +: 8] <= mem[rd_idx][OFF_W'(rd_wrap(rd_off, i))];
      end
    end
  end

  function automatic logic [OFF_W-1:0] rd_wrap(input logic [OFF_W-1:0] off, input int i);
    return OFF_W'(off + OFF_W'(i));
  endfunction

endmodule

// File: rtl/cache_data_array.sv
// Multi-way L1 data array: store port, registered read port and a burst refill engine
// that writes one line from memory an 8-byte beat at a time.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned RD_BYTES   = 8,
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [WAY_W-1:0]      rd_way,
  input  logic [63:0]           rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [8*RD_BYTES-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [WAY_W-1:0]      wr_way,
  input  logic [63:0]           wr_addr,
  input  logic [7:0]            wr_strb,
  input  logic [63:0]           wr_data,
  output logic                  wr_ready,
  input  logic                  refill_start,
  input  logic [WAY_W-1:0]      refill_way,
  input  logic [63:0]           refill_addr,
  input  logic                  refill_beat_valid,
  input  logic [63:0]           refill_data,
  output logic                  refill_ready,
  output logic                  refill_done
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  refill_state_t     state, state_nx;
  logic [BEAT_W-1:0] beat, beat_nx;
  logic [WAY_W-1:0]  fill_way, rd_way_q;
  logic [IDX_W-1:0]  fill_idx;
  logic              ready_q;

  logic                  rd_acc_c, fill_wr_c, store_acc_c;
  logic [IDX_W-1:0]      rd_idx_c, wr_idx_c;
  logic [OFF_W-1:0]      rd_off_c, wr_off_c;
  logic [7:0]            wr_strb_c;
  logic [63:0]           wr_data_c;
  logic [WAYS-1:0]       bank_wr_c;
  logic [8*RD_BYTES-1:0] bank_rd [WAYS];

  assign rd_idx_c = IDX_W'(addr_index(rd_addr, OFF_W, IDX_W));
  assign rd_off_c = OFF_W'(addr_offset(rd_addr, OFF_W));

  // Reads stall only against the line currently being refilled.
  assign rd_ready    = !((state != RF_IDLE) && (rd_way == fill_way) && (rd_idx_c == fill_idx));
  assign rd_acc_c    = rd_req && rd_ready;
  assign fill_wr_c   = (state == RF_FILL) && refill_beat_valid;
  assign store_acc_c = wr_en && (state == RF_IDLE);

  assign wr_ready     = ready_q;
  assign refill_ready = ready_q;

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    case (state)
      RF_IDLE: begin
        if (refill_start) begin
          state_nx = RF_FILL;
          beat_nx  = '0;
        end
      end
      RF_FILL: begin
        if (refill_beat_valid) begin
          beat_nx = BEAT_W'(beat + BEAT_W'(1));
          if (beat == BEAT_W'(BEATS - 1)) state_nx = RF_DONE;
        end
      end
      RF_DONE: state_nx = RF_IDLE;
      default: state_nx = RF_IDLE;
    endcase
  end

  // Single bank write port: refill beats own it in FILL, stores only land in IDLE.
  always_comb begin
    wr_idx_c  = fill_wr_c ? fill_idx : IDX_W'(addr_index(wr_addr, OFF_W, IDX_W));
    wr_off_c  = fill_wr_c ? OFF_W'({beat, 3'b000}) : OFF_W'(addr_offset(wr_addr, OFF_W));
    wr_strb_c = fill_wr_c ? 8'hFF : wr_strb;
    wr_data_c = fill_wr_c ? refill_data : wr_data;
    bank_wr_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      bank_wr_c[w] = fill_wr_c ? (fill_way == WAY_W'(w)) : (store_acc_c && (wr_way == WAY_W'(w)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RF_IDLE;
      beat        <= '0;
      ready_q     <= 1'b1;
      refill_done <= 1'b0;
      rd_valid    <= 1'b0;
      rd_way_q    <= '0;
      fill_way    <= '0;
      fill_idx    <= '0;
    end else begin
      state       <= state_nx;
      beat        <= beat_nx;
      ready_q     <= (state_nx == RF_IDLE);
      refill_done <= (state_nx == RF_DONE);
      rd_valid    <= rd_acc_c;
      if (rd_acc_c) rd_way_q <= rd_way;
      if ((state == RF_IDLE) && refill_start) begin
        fill_way <= refill_way;
        fill_idx <= IDX_W'(addr_index(refill_addr, OFF_W, IDX_W));
      end
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_data_bank #(
      .LINE_BYTES(LINE_BYTES),
      .SETS      (SETS),
      .RD_BYTES  (RD_BYTES)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_en  (rd_acc_c),
      .rd_idx (rd_idx_c),
      .rd_off (rd_off_c),
      .rd_data(bank_rd[w]),
      .wr_en  (bank_wr_c[w]),
      .wr_idx (wr_idx_c),
      .wr_off (wr_off_c),
      .wr_strb(wr_strb_c),
      .wr_data(wr_data_c)
    );
  end

  // Banks hold their read register between reads, so the muxed output holds too.
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_way_q == WAY_W'(w)) rd_data = bank_rd[w];
    end
  end

endmodule

// File: tb/tb_cache_data_array.sv
// Directed self-checking bench for cache_data_array at default geometry (64B lines, 64 sets, 2 ways).
module tb_cache_data_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [0:0]  rd_way;
  logic [63:0] rd_addr;
  logic        rd_ready, rd_valid;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [0:0]  wr_way;
  logic [63:0] wr_addr;
  logic [7:0]  wr_strb;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        refill_start;
  logic [0:0]  refill_way;
  logic [63:0] refill_addr;
  logic        refill_beat_valid;
  logic [63:0] refill_data;
  logic        refill_ready, refill_done;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt;
  int done_cyc;

  always #5 clk = ~clk;

  cache_data_array dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_way(rd_way), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .refill_start(refill_start), .refill_way(refill_way), .refill_addr(refill_addr),
    .refill_beat_valid(refill_beat_valid), .refill_data(refill_data),
    .refill_ready(refill_ready), .refill_done(refill_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s);
    wr_en = 1'b1; wr_way = w; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic w, input logic [63:0] a,
                         input logic [63:0] exp);
    rd_req = 1'b1; rd_way = w; rd_addr = a;
    tick();
    rd_req = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_way = '0; rd_addr = '0;
    wr_en = 1'b0; wr_way = '0; wr_addr = '0; wr_strb = '0; wr_data = '0;
    refill_start = 1'b0; refill_way = '0; refill_addr = '0;
    refill_beat_valid = 1'b0; refill_data = '0;
    tick(); tick();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_refill_ready", 64'(refill_ready), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_refill_done", 64'(refill_done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Way separation at addr 0x0C8 (set 3, offset 8)
    do_store(1'b0, 64'h0C8, 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF);
    do_store(1'b1, 64'h0C8, 64'h1122_3344_5566_7788, 8'hFF);
    do_read("way1_c8", 1'b1, 64'h0C8, 64'h1122_3344_5566_7788);
    do_read("way0_c8", 1'b0, 64'h0C8, 64'hA0A1_A2A3_A4A5_A6A7);
    tick();
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);
    chk("hold_rd_data", rd_data, 64'hA0A1_A2A3_A4A5_A6A7);

    // Line wrap: offsets 0..7 = 00..07, 56..63 = F0..F7, then partial store at offset 60
    do_store(1'b0, 64'h000, 64'h0706_0504_0302_0100, 8'hFF);
    do_store(1'b0, 64'h038, 64'hF7F6_F5F4_F3F2_F1F0, 8'hFF);
    do_store(1'b0, 64'h03C, 64'hDDCC_BBAA_4433_2211, 8'h0F);
    do_read("wrap_rd", 1'b0, 64'h03C, 64'h0302_0100_4433_2211);
    do_store(1'b0, 64'h03C, 64'h0D0C_0B0A_0000_0000, 8'hF0);
    do_read("wrap_wr", 1'b0, 64'h03C, 64'h0D0C_0B0A_4433_2211);
    do_read("wrap_wr_base", 1'b0, 64'h000, 64'h0706_0504_0D0C_0B0A);
    do_store(1'b0, 64'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    do_read("strb0_noop", 1'b0, 64'h000, 64'h0706_0504_0D0C_0B0A);

    // Same-cycle read and store: read-before-write
    rd_req = 1'b1; rd_way = 1'b0; rd_addr = 64'h000;
    wr_en = 1'b1; wr_way = 1'b0; wr_addr = 64'h000; wr_data = 64'h5555_6666_7777_8888;
    wr_strb = 8'hFF;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    chk("rbw_old", rd_data, 64'h0706_0504_0D0C_0B0A);
    do_read("rbw_new", 1'b0, 64'h000, 64'h5555_6666_7777_8888);

    // Refill way 0, set 5 with a 2-cycle gap after beat 3
    do_store(1'b1, 64'h140, 64'h9999_9999_9999_9999, 8'hFF);
    do_store(1'b1, 64'h180, 64'h7777_7777_7777_7777, 8'hFF);
    refill_start = 1'b1; refill_way = 1'b0; refill_addr = 64'h145;
    tick();
    refill_start = 1'b0;
    done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (refill_done) begin done_cnt++; done_cyc = c; end
      refill_beat_valid = (c <= 4) || (c >= 7 && c <= 10);
      refill_data = 64'hBEEF_0000_0000_0000 | 64'((c <= 4) ? c - 1 : c - 3);
      rd_req = (c <= 11); rd_way = (c == 5) ? 1'b1 : 1'b0; rd_addr = 64'h140;
      wr_en = (c == 6); wr_way = 1'b1; wr_addr = 64'h180;
      wr_data = 64'h3333_3333_3333_3333; wr_strb = 8'hFF;
      #1;
      if (c == 2 || c == 5 || c == 8 || c == 11)
        chk($sformatf("fill_rd_ready_c%0d", c), 64'(rd_ready), (c == 5) ? 64'd1 : 64'd0);
      if (c == 6) begin
        chk("fill_wr_ready", 64'(wr_ready), 64'd0);
        chk("fill_other_way_valid", 64'(rd_valid), 64'd1);
        chk("fill_other_way_data", rd_data, 64'h9999_9999_9999_9999);
      end
      if (c == 11) chk("fill_refill_ready_done", 64'(refill_ready), 64'd0);
      if (c == 12) begin
        chk("fill_refill_ready_after", 64'(refill_ready), 64'd1);
        chk("fill_wr_ready_after", 64'(wr_ready), 64'd1);
      end
      tick();
    end
    refill_beat_valid = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    chk("fill_done_count", 64'(done_cnt), 64'd1);
    chk("fill_done_cycle", 64'(done_cyc), 64'd11);
    do_read("fill_beat0", 1'b0, 64'h140, 64'hBEEF_0000_0000_0000);
    do_read("fill_beat7", 1'b0, 64'h178, 64'hBEEF_0000_0000_0007);
    do_read("fill_beat3_4", 1'b0, 64'h15C, 64'h0000_0004_BEEF_0000);
    do_read("fill_store_dropped", 1'b1, 64'h180, 64'h7777_7777_7777_7777);
    do_store(1'b1, 64'h180, 64'h3333_3333_3333_3333, 8'hFF);
    do_read("store_after_done", 1'b1, 64'h180, 64'h3333_3333_3333_3333);

    // Reset after beat 4 of a refill to way 1, set 7
    refill_start = 1'b1; refill_way = 1'b1; refill_addr = 64'h1C0;
    tick();
    refill_start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      refill_beat_valid = 1'b1; refill_data = 64'hDEAD_0000_0000_0000 | 64'(c - 1);
      tick();
      if (refill_done) done_cnt++;
    end
    refill_beat_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_refill_ready", 64'(refill_ready), 64'd1);
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      refill_beat_valid = 1'b1;
      tick();
      if (refill_done) done_cnt++;
    end
    refill_beat_valid = 1'b0;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle_ready", 64'(refill_ready), 64'd1);

    refill_start = 1'b1; refill_way = 1'b1; refill_addr = 64'h1C0;
    tick();
    refill_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 9) chk("refill2_done", 64'(refill_done), 64'd1);
      if (c == 10) begin
        chk("refill2_done_clear", 64'(refill_done), 64'd0);
        chk("refill2_ready", 64'(refill_ready), 64'd1);
      end
      refill_beat_valid = (c <= 8);
      refill_data = 64'hC0DE_0000_0000_0000 | 64'(c - 1);
      tick();
    end
    refill_beat_valid = 1'b0;
    do_read("refill2_beat0", 1'b1, 64'h1C0, 64'hC0DE_0000_0000_0000);
    do_read("refill2_beat5", 1'b1, 64'h1E8, 64'hC0DE_0000_0000_0005);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
